pq_loader: RTL and testbench
============================

# pq_loader

Upstream feeder stage for the hardware priority queue. Accepts `<key,value>` pairs from a producer on a valid/ready port and buffers them in a small FIFO. Issues them one at a time into the insert side of the PQ client interface, respecting `busy` and `full`. Keeps saturating insert and stall counters for the HWPQ study.

## Interface
Parameters:
- `FIFO_DEPTH`, 4: entries of `kv_t` buffered (power of two, ≥2).
- `CNT_WIDTH`, 16: width of statistic counters.

Ports:
- `clk`: input, 1. Single clock, rising edge.
- `rst`: input, 1. Asynchronous, active-high reset.
- `s_valid`: input, 1. Producer offers `s_kv`.
- `s_ready`: output, 1. Loader can accept.
- `s_kv`: input, `kv_t` (`KEY_WIDTH+VAL_WIDTH`). Offered pair.
- `flush`: input, 1. Discard buffered, un-issued pairs.
- `pq_ivalid`: output, 1. Insert request to PQ.
- `pq_irdy`: input, 1. PQ accepts insert.
- `pq_idata`: output, `kv_t`. Pair being inserted.
- `pq_busy`: input, 1. PQ internal operation in progress.
- `pq_full`: input, 1. PQ at `PQ_CAPACITY`.
- `fifo_count`: output, `$clog2(FIFO_DEPTH)+1`. Entries buffered.
- `ins_count`: output, `CNT_WIDTH`. Completed inserts, saturating.
- `stall_count`: output, `CNT_WIDTH`. Stall cycles, saturating.

## Operation
- **Producer side:** `s_ready = (fifo_count < FIFO_DEPTH) && !flush`. A push occurs on an edge where `s_valid && s_ready`.
- **FSM states:** `IDLE`, `ISSUE`, `SETTLE`.
  - `IDLE`: `pq_ivalid=0`. Go to `ISSUE` when `fifo_count != 0 && !pq_busy && !pq_full && !flush`.
  - `ISSUE`: `pq_ivalid=1`, with `pq_idata` = FIFO head.
    - Hold `pq_ivalid` and `pq_idata` stable until `pq_irdy`. Never retract, even if `pq_full` or `flush` rises meanwhile.
    - On `pq_irdy`: pop the head, increment `ins_count`, go to `SETTLE`.
  - `SETTLE`: `pq_ivalid=0`. Always spend at least one cycle here. Go to `IDLE` on the first cycle with `!pq_busy`.
- **Outstanding inserts:** at most one in flight.
- **Simultaneous push and pop:** `fifo_count` is unchanged and ordering is preserved (FIFO order).
- **Flush:** synchronous, one cycle.
  - In `IDLE` or `SETTLE`, the FIFO is emptied.
  - In `ISSUE`, the head entry stays until its handshake completes and all other entries are discarded.
  - A push is impossible during a flush cycle because `s_ready=0`.
- **`stall_count`:** increments once per cycle in either of these cases:
  - in `ISSUE` with `!pq_irdy`;
  - in `IDLE` with `fifo_count != 0 && (pq_busy || pq_full)`.
- **Counter saturation:** both counters stop at `2^CNT_WIDTH-1` and do not wrap.
- **Reset:** asserting `rst` immediately forces the following, independent of `clk`:
  - state `IDLE`;
  - `pq_ivalid=0`, `pq_idata=0`;
  - FIFO empty, `fifo_count=0`;
  - `ins_count=0`, `stall_count=0`;
  - `s_ready=1` once `rst` deasserts (`flush` low).
  
  Reset mid-`ISSUE` abandons the insert. The PQ shares `rst`, so no partial insert survives.

## Timing
- Outputs `pq_ivalid`, `pq_idata`, `fifo_count` and the counters are registered or decoded from registered state only. `s_ready` additionally depends combinationally on `flush`.
- **Latency:** with the loader empty and in `IDLE`, the PQ idle and not full, a pair pushed on edge t gives `pq_ivalid=1` after edge t+2.
- **Throughput:** best case is one insert per 3 cycles (`ISSUE` → `SETTLE` → `IDLE`), with `pq_irdy` immediate and `pq_busy` low.
- **Wrap-around:** FIFO read and write pointers wrap modulo `FIFO_DEPTH`. Full versus empty is distinguished by `fifo_count`.

## Structure
- Add to `pq_pkg`:
  - `loader_state_t` enum {`IDLE`, `ISSUE`, `SETTLE`};
  - `localparam KV_WIDTH = KEY_WIDTH+VAL_WIDTH`.
- `kv_t` is reused from `pq_pkg` unchanged.
- One sub-module, `pq_kv_fifo`: a parameterized synchronous `kv_t` FIFO with push, pop, flush-except-head, head output and count. The FSM and counters stay in `pq_loader`.

## Test plan
- **Single insert:** after reset, push `{key=3,val=5}`, PQ idle, `pq_irdy` tied 1 → `pq_ivalid` high after edge t+2, `pq_idata=0x35`, `ins_count=1`, `fifo_count=0`.
- **Fill and backpressure:** push 5 pairs back-to-back while `pq_busy=1` → `s_ready` drops after the 4th push, `fifo_count=4`. Release `pq_busy` → inserts emerge in push order, `ins_count=4`.
- **Full PQ:** `pq_full=1` with 2 entries buffered for 10 cycles → `pq_ivalid=0`, `stall_count=10`. Drop `pq_full` → both issued.
- **Hold during stall:** in `ISSUE`, keep `pq_irdy=0` for 3 cycles and raise `pq_full` meanwhile → `pq_ivalid` and `pq_idata` stable, `stall_count` +3. Insert completes when `pq_irdy=1`.
- **Flush mid-issue:** 3 entries buffered, flush while in `ISSUE` → the head still completes, `fifo_count=0` afterwards, `ins_count` +1 only.
- **Reset mid-operation:** assert `rst` asynchronously mid-`ISSUE` → `pq_ivalid=0` immediately, all counts 0. After release, a new push issues normally.

Source files
------------

// File: rtl/pq_pkg.sv
// Shared types and constants for the hardware priority queue and its feeder.
package pq_pkg;

  localparam int KEY_WIDTH   = 4;
  localparam int VAL_WIDTH   = 4;
  localparam int PQ_CAPACITY = 16;
  localparam int KV_WIDTH    = KEY_WIDTH + VAL_WIDTH;

  typedef struct packed {
    logic [KEY_WIDTH-1:0] key;
    logic [VAL_WIDTH-1:0] val;
  } kv_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    SETTLE = 2'd2
  } loader_state_t;

endpackage

// File: rtl/pq_kv_fifo.sv
// Small synchronous kv_t FIFO with push, pop, head output and a flush that can
// optionally preserve the head entry while it is being handed to the PQ.
module pq_kv_fifo
  import pq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  kv_t                      push_kv,
  input  logic                     pop,
  input  logic                     flush,
  input  logic                     keep_head,
  output kv_t                      head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  kv_t           mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign push_ok = push && (count < CW'(DEPTH)) && !flush;
  assign pop_ok  = pop && (count != '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      // Keeping the head means everything behind it is dropped.
      if (keep_head && !pop_ok && (count != '0)) begin
        wr_ptr <= rd_ptr + AW'(1);
        count  <= CW'(1);
      end else begin
        rd_ptr <= rd_ptr + AW'(pop_ok);
        wr_ptr <= rd_ptr + AW'(pop_ok);
        count  <= '0;
      end
    end else begin
      wr_ptr <= wr_ptr + AW'(push_ok);
      rd_ptr <= rd_ptr + AW'(pop_ok);
      count  <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_kv;
  end

endmodule

// File: rtl/pq_loader.sv
// Feeder stage: buffers producer pairs and issues them one at a time into the
// PQ insert port, with saturating insert and stall statistics.
//
//   state  | meaning
//   IDLE   | no insert outstanding; waiting for a buffered pair and a ready PQ
//   ISSUE  | pq_ivalid held with FIFO head until pq_irdy
//   SETTLE | insert accepted; waiting for the PQ to drop busy
module pq_loader
  import pq_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  kv_t                           s_kv,
  input  logic                          flush,
  output logic                          pq_ivalid,
  input  logic                          pq_irdy,
  output kv_t                           pq_idata,
  input  logic                          pq_busy,
  input  logic                          pq_full,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [CNT_WIDTH-1:0]          ins_count,
  output logic [CNT_WIDTH-1:0]          stall_count
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  loader_state_t state, state_nxt;
  kv_t           head;
  logic          push;
  logic          pop;
  logic          pend_q;
  logic          stall_evt;

  assign s_ready = (fifo_count < CW'(FIFO_DEPTH)) && !flush;
  assign push    = s_valid && s_ready;
  assign pop     = (state == ISSUE) && pq_irdy;

  pq_kv_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_kv   (s_kv),
    .pop       (pop),
    .flush     (flush),
    .keep_head (state == ISSUE),
    .head      (head),
    .count     (fifo_count)
  );

  // An entry is only offered once it has sat in the FIFO for a full cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pend_q <= 1'b0;
    else     pend_q <= (fifo_count != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pq_ivalid = 1'b0;
    pq_idata  = '0;
    stall_evt = 1'b0;
    case (state)
      IDLE: begin
        stall_evt = (fifo_count != '0) && (pq_busy || pq_full);
        if ((fifo_count != '0) && pend_q && !pq_busy && !pq_full && !flush)
          state_nxt = ISSUE;
      end
      ISSUE: begin
        pq_ivalid = 1'b1;
        pq_idata  = head;
        stall_evt = !pq_irdy;
        if (pq_irdy) state_nxt = SETTLE;
      end
      SETTLE: begin
        if (!pq_busy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ins_count   <= '0;
      stall_count <= '0;
    end else begin
      if (pop && (ins_count != '1))
        ins_count <= ins_count + CNT_WIDTH'(1);
      if (stall_evt && (stall_count != '1))
        stall_count <= stall_count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_pq_loader.sv
// Scenario bench for pq_loader: scoreboard of pushed pairs checked at each insert handshake.
module tb_pq_loader;
  import pq_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid;
  logic        s_ready;
  kv_t         s_kv;
  logic        flush;
  logic        pq_ivalid;
  logic        pq_irdy;
  kv_t         pq_idata;
  logic        pq_busy;
  logic        pq_full;
  logic [2:0]  fifo_count;
  logic [15:0] ins_count;
  logic [15:0] stall_count;

  int tests = 0;
  int fails = 0;
  kv_t sb[$];

  pq_loader #(.FIFO_DEPTH(4), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_kv(s_kv),
    .flush(flush), .pq_ivalid(pq_ivalid), .pq_irdy(pq_irdy), .pq_idata(pq_idata),
    .pq_busy(pq_busy), .pq_full(pq_full), .fifo_count(fifo_count),
    .ins_count(ins_count), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  // Insert handshakes complete on the next rising edge; check the pair against the scoreboard.
  always @(negedge clk) begin
    if (!rst && pq_ivalid && pq_irdy) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL insert_unexpected: got %h, scoreboard empty", pq_idata);
      end else begin
        kv_t exp_kv;
        exp_kv = sb.pop_front();
        if (pq_idata !== exp_kv) begin
          fails++;
          $display("FAIL insert_order: got %h, expected %h", pq_idata, exp_kv);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input kv_t kv);
    s_valid = 1'b1;
    s_kv    = kv;
    #1;
    tests++;
    if (s_ready !== 1'b1) begin
      fails++;
      $display("FAIL push_ready: s_ready=%b, expected 1", s_ready);
    end else begin
      sb.push_back(kv);
    end
    tick();
    s_valid = 1'b0;
  endtask

  task automatic wait_ivalid(input int max_cyc);
    int n;
    n = 0;
    while (pq_ivalid !== 1'b1 && n < max_cyc) begin
      tick();
      n++;
    end
    tests++;
    if (pq_ivalid !== 1'b1) begin
      fails++;
      $display("FAIL wait_ivalid: pq_ivalid=%b after %0d cycles, expected 1", pq_ivalid, n);
    end
  endtask

  task automatic wait_ins(input logic [15:0] target, input int max_cyc);
    int n;
    n = 0;
    while (ins_count !== target && n < max_cyc) begin
      tick();
      n++;
    end
    tests++;
    if (ins_count !== target) begin
      fails++;
      $display("FAIL wait_ins: ins_count=%0d, expected %0d", ins_count, target);
    end
  endtask

  task automatic test_reset();
    #1;
    tests++;
    if (pq_ivalid !== 1'b0 || pq_idata !== kv_t'(0) || fifo_count !== 3'd0 ||
        ins_count !== 16'd0 || stall_count !== 16'd0) begin
      fails++;
      $display("FAIL reset_state: ivalid=%b idata=%h fifo=%0d ins=%0d stall=%0d, expected all 0",
               pq_ivalid, pq_idata, fifo_count, ins_count, stall_count);
    end
    tick();
    rst = 1'b0;
    #1;
    tests++;
    if (s_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready: s_ready=%b, expected 1", s_ready);
    end
  endtask

  task automatic test_single();
    pq_irdy = 1'b1;
    push_one(kv_t'(8'h35));                    // edge t
    tests++;
    if (fifo_count !== 3'd1 || pq_ivalid !== 1'b0) begin
      fails++;
      $display("FAIL single_t: fifo=%0d ivalid=%b, expected 1/0", fifo_count, pq_ivalid);
    end
    tick();                                    // edge t+1
    tests++;
    if (pq_ivalid !== 1'b0) begin
      fails++;
      $display("FAIL single_t1: ivalid=%b, expected 0", pq_ivalid);
    end
    tick();                                    // edge t+2
    tests++;
    if (pq_ivalid !== 1'b1 || pq_idata !== kv_t'(8'h35)) begin
      fails++;
      $display("FAIL single_t2: ivalid=%b idata=%h, expected 1/35", pq_ivalid, pq_idata);
    end
    tick();
    tests++;
    if (ins_count !== 16'd1 || fifo_count !== 3'd0 || stall_count !== 16'd0) begin
      fails++;
      $display("FAIL single_done: ins=%0d fifo=%0d stall=%0d, expected 1/0/0",
               ins_count, fifo_count, stall_count);
    end
    repeat (2) tick();
  endtask

  task automatic test_fill();
    logic [15:0] ins0;
    ins0 = ins_count;
    pq_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1;
      s_kv    = kv_t'(8'hA0 + i);
      #1;
      tests++;
      if (s_ready !== (i < 4)) begin
        fails++;
        $display("FAIL fill_ready_%0d: s_ready=%b, expected %b", i, s_ready, (i < 4));
      end
      if (s_ready === 1'b1) sb.push_back(kv_t'(8'hA0 + i));
      tick();
    end
    s_valid = 1'b0;
    tests++;
    if (fifo_count !== 3'd4 || pq_ivalid !== 1'b0) begin
      fails++;
      $display("FAIL fill_count: fifo=%0d ivalid=%b, expected 4/0", fifo_count, pq_ivalid);
    end
    pq_busy = 1'b0;
    wait_ins(ins0 + 16'd4, 40);
    tick();
    tests++;
    if (fifo_count !== 3'd0) begin
      fails++;
      $display("FAIL fill_drain: fifo=%0d, expected 0", fifo_count);
    end
    repeat (2) tick();
  endtask

  task automatic test_full();
    logic [15:0] st0, ins0;
    ins0 = ins_count;
    pq_full = 1'b1;
    push_one(kv_t'(8'h71));
    push_one(kv_t'(8'h72));
    st0 = stall_count;
    for (int i = 0; i < 10; i++) begin
      tick();
      tests++;
      if (pq_ivalid !== 1'b0) begin
        fails++;
        $display("FAIL full_ivalid_%0d: ivalid=%b, expected 0", i, pq_ivalid);
      end
    end
    tests++;
    if (stall_count - st0 !== 16'd10) begin
      fails++;
      $display("FAIL full_stall: delta=%0d, expected 10", stall_count - st0);
    end
    pq_full = 1'b0;
    wait_ins(ins0 + 16'd2, 20);
    repeat (3) tick();
  endtask

  task automatic test_hold();
    logic [15:0] st0, ins0;
    kv_t d0;
    pq_irdy = 1'b0;
    push_one(kv_t'(8'hC9));
    wait_ivalid(10);
    st0  = stall_count;
    ins0 = ins_count;
    d0   = pq_idata;
    for (int i = 0; i < 3; i++) begin
      tick();
      pq_full = 1'b1;
      tests++;
      if (pq_ivalid !== 1'b1 || pq_idata !== d0 || d0 !== kv_t'(8'hC9)) begin
        fails++;
        $display("FAIL hold_stable_%0d: ivalid=%b idata=%h, expected 1/c9", i, pq_ivalid, pq_idata);
      end
    end
    tests++;
    if (stall_count - st0 !== 16'd3) begin
      fails++;
      $display("FAIL hold_stall: delta=%0d, expected 3", stall_count - st0);
    end
    pq_irdy = 1'b1;
    tick();
    tests++;
    if (ins_count !== ins0 + 16'd1 || pq_ivalid !== 1'b0) begin
      fails++;
      $display("FAIL hold_done: ins=%0d ivalid=%b, expected %0d/0", ins_count, pq_ivalid, ins0 + 16'd1);
    end
    pq_full = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_flush();
    logic [15:0] ins0;
    pq_busy = 1'b1;
    pq_irdy = 1'b0;
    push_one(kv_t'(8'h11));
    push_one(kv_t'(8'h22));
    push_one(kv_t'(8'h33));
    pq_busy = 1'b0;
    wait_ivalid(10);
    ins0 = ins_count;
    flush = 1'b1;
    #1;
    tests++;
    if (s_ready !== 1'b0) begin
      fails++;
      $display("FAIL flush_ready: s_ready=%b, expected 0", s_ready);
    end
    while (sb.size() > 1) void'(sb.pop_back());
    tick();
    flush = 1'b0;
    tests++;
    if (fifo_count !== 3'd1 || pq_ivalid !== 1'b1 || pq_idata !== kv_t'(8'h11)) begin
      fails++;
      $display("FAIL flush_head: fifo=%0d ivalid=%b idata=%h, expected 1/1/11",
               fifo_count, pq_ivalid, pq_idata);
    end
    pq_irdy = 1'b1;
    tick();
    repeat (6) tick();
    tests++;
    if (ins_count !== ins0 + 16'd1 || fifo_count !== 3'd0 || pq_ivalid !== 1'b0) begin
      fails++;
      $display("FAIL flush_done: ins=%0d fifo=%0d ivalid=%b, expected %0d/0/0",
               ins_count, fifo_count, pq_ivalid, ins0 + 16'd1);
    end
  endtask

  task automatic test_reset_mid();
    pq_irdy = 1'b0;
    push_one(kv_t'(8'h5A));
    push_one(kv_t'(8'h5B));
    wait_ivalid(10);
    #2;
    rst = 1'b1;
    #1;
    tests++;
    if (pq_ivalid !== 1'b0 || pq_idata !== kv_t'(0) || fifo_count !== 3'd0 ||
        ins_count !== 16'd0 || stall_count !== 16'd0) begin
      fails++;
      $display("FAIL reset_mid: ivalid=%b idata=%h fifo=%0d ins=%0d stall=%0d, expected all 0",
               pq_ivalid, pq_idata, fifo_count, ins_count, stall_count);
    end
    sb.delete();
    tick();
    #2;
    rst = 1'b0;
    tick();
    pq_irdy = 1'b1;
    push_one(kv_t'(8'hE4));
    wait_ins(16'd1, 10);
    repeat (2) tick();
  endtask

  initial begin
    rst     = 1'b1;
    s_valid = 1'b0;
    s_kv    = '0;
    flush   = 1'b0;
    pq_irdy = 1'b0;
    pq_busy = 1'b0;
    pq_full = 1'b0;
    test_reset();
    test_single();
    test_fill();
    test_full();
    test_hold();
    test_flush();
    test_reset_mid();
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d pairs never inserted, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
